// File: rtl/gsim_param.sv
// Gauss-Seidel solver for the banded system (20; -13, 6, -1) with N unknowns,
// sweep limit, tolerance-based early exit and a valid/ready result stream.
module gsim_param #(
    parameter int unsigned N    = 16,
    parameter int unsigned B_W  = 16,
    parameter int unsigned X_W  = 32,
    parameter int unsigned FRAC = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_en,
    input  logic [B_W-1:0] b_in,
    input  logic [15:0]    iter_max,
    input  logic [X_W-1:0] tol,
    output logic           in_ready,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [X_W-1:0] x_out,
    output logic [5:0]     out_idx,
    output logic           converged,
    output logic [15:0]    iter_cnt
);

    localparam int unsigned AW    = $clog2(N);
    localparam int unsigned ACC_W = X_W + 24;

    localparam logic signed [ACC_W-1:0] K13   = ACC_W'(13);
    localparam logic signed [ACC_W-1:0] K6    = ACC_W'(6);
    localparam logic signed [ACC_W-1:0] KRCP  = ACC_W'(52429);
    localparam logic signed [ACC_W-1:0] KRND  = ACC_W'(524288);

    typedef enum logic [1:0] {StIdle, StLoad, StIter, StOut} state_e;

    state_e                    state_q, state_d;
    logic [AW-1:0]             idx_q, idx_d;
    logic signed [B_W-1:0]     b_q [N];
    logic signed [X_W-1:0]     x_q [N];
    logic [15:0]               iter_max_q, cnt_q;
    logic [X_W-1:0]            tol_q;
    logic [X_W:0]              dmax_q;
    logic                      sweep_end_q, conv_q;

    logic                      last, load_en, start, x_we, finish, stop_tol, stop;
    logic signed [X_W-1:0]     nb_lo [3];
    logic signed [X_W-1:0]     nb_hi [3];
    logic signed [X_W-1:0]     x_old, x_new;
    logic signed [ACC_W-1:0]   p1, p2, p3, s, prod, q;
    logic                      ovf;
    logic signed [X_W:0]       diff;
    logic [X_W:0]              absd, dmax_nxt;

    assign last      = (idx_q == AW'(N - 1));
    assign in_ready  = (state_q == StIdle) || (state_q == StLoad);
    assign busy      = (state_q == StIter) || (state_q == StOut);
    assign out_valid = (state_q == StOut);
    assign load_en   = in_en && in_ready;
    assign x_out     = out_valid ? x_q[idx_q] : '0;
    assign out_idx   = out_valid ? 6'(idx_q) : '0;
    assign converged = conv_q;
    assign iter_cnt  = cnt_q;

    // x[i-k] already hold this sweep's values because updates are done in place.
    always_comb begin
        for (int k = 1; k <= 3; k++) begin
            nb_lo[k-1] = '0;
            nb_hi[k-1] = '0;
            if (int'(idx_q) >= k) nb_lo[k-1] = x_q[AW'(int'(idx_q) - k)];
            if (int'(idx_q) + k < int'(N)) nb_hi[k-1] = x_q[AW'(int'(idx_q) + k)];
        end
    end

    always_comb begin
        x_old = x_q[idx_q];
        p1    = ACC_W'(nb_lo[0]) + ACC_W'(nb_hi[0]);
        p2    = ACC_W'(nb_lo[1]) + ACC_W'(nb_hi[1]);
        p3    = ACC_W'(nb_lo[2]) + ACC_W'(nb_hi[2]);
        s     = (ACC_W'(b_q[idx_q]) <<< FRAC) + K13 * p1 - K6 * p2 + p3;
        prod  = s * KRCP + KRND;
        q     = prod >>> 20;
        ovf   = (q[ACC_W-1:X_W-1] != {(ACC_W - X_W + 1){q[ACC_W-1]}});
        if (ovf) x_new = q[ACC_W-1] ? {1'b1, {(X_W - 1){1'b0}}} : {1'b0, {(X_W - 1){1'b1}}};
        else     x_new = q[X_W-1:0];
        diff     = {x_new[X_W-1], x_new} - {x_old[X_W-1], x_old};
        absd     = diff[X_W] ? -diff : diff;
        dmax_nxt = (idx_q == '0 || absd > dmax_q) ? absd : dmax_q;
        stop_tol = (dmax_q <= {1'b0, tol_q});
        stop     = stop_tol || (cnt_q == iter_max_q);
    end

    // The end-of-sweep decision is taken in the slot of the next sweep's first update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        start   = 1'b0;
        x_we    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_en) begin
                    start   = 1'b1;
                    state_d = StLoad;
                    idx_d   = AW'(1);
                end
            end
            StLoad: begin
                if (in_en) begin
                    idx_d = idx_q + 1'b1;
                    if (last) begin
                        state_d = StIter;
                        idx_d   = '0;
                    end
                end
            end
            StIter: begin
                if (sweep_end_q && idx_q == '0 && stop) begin
                    finish  = 1'b1;
                    state_d = StOut;
                end else begin
                    x_we  = 1'b1;
                    idx_d = last ? '0 : idx_q + 1'b1;
                end
            end
            StOut: begin
                if (out_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (last) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            iter_max_q  <= '0;
            tol_q       <= '0;
            cnt_q       <= '0;
            conv_q      <= 1'b0;
            dmax_q      <= '0;
            sweep_end_q <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                b_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load_en) b_q[idx_q] <= b_in;
            if (start) begin
                for (int i = 0; i < int'(N); i++) x_q[i] <= '0;
                iter_max_q  <= (iter_max == '0) ? 16'd1 : iter_max;
                tol_q       <= tol;
                cnt_q       <= '0;
                conv_q      <= 1'b0;
                sweep_end_q <= 1'b0;
            end
            if (x_we) begin
                x_q[idx_q]  <= x_new;
                dmax_q      <= dmax_nxt;
                sweep_end_q <= last;
                if (last) cnt_q <= cnt_q + 16'd1;
            end
            if (finish) begin
                conv_q      <= stop_tol;
                sweep_end_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gsim_param.sv
// Scoreboard bench for gsim_param: N=16, 8 and 4 instances against a behavioural
// Gauss-Seidel model, with latency, backpressure, gap, ignore and reset checks.
module tb_gsim_param;

    typedef struct {
        int     idx;
        longint x;
        int     cnt;
        bit     conv;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_en     [3];
    logic [15:0] b_in      [3];
    logic [15:0] iter_max  [3];
    logic [31:0] tol       [3];
    logic        in_ready  [3];
    logic        busy      [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] x_out     [3];
    logic [5:0]  out_idx   [3];
    logic        converged [3];
    logic [15:0] iter_cnt  [3];

    gsim_param #(.N(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_en(in_en[0]), .b_in(b_in[0]), .iter_max(iter_max[0]),
        .tol(tol[0]), .in_ready(in_ready[0]), .busy(busy[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .x_out(x_out[0]), .out_idx(out_idx[0]),
        .converged(converged[0]), .iter_cnt(iter_cnt[0])
    );
    gsim_param #(.N(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_en(in_en[1]), .b_in(b_in[1]), .iter_max(iter_max[1]),
        .tol(tol[1]), .in_ready(in_ready[1]), .busy(busy[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .x_out(x_out[1]), .out_idx(out_idx[1]),
        .converged(converged[1]), .iter_cnt(iter_cnt[1])
    );
    gsim_param #(.N(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_en(in_en[2]), .b_in(b_in[2]), .iter_max(iter_max[2]),
        .tol(tol[2]), .in_ready(in_ready[2]), .busy(busy[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .x_out(x_out[2]), .out_idx(out_idx[2]),
        .converged(converged[2]), .iter_cnt(iter_cnt[2])
    );

    int     n_checks = 0;
    int     n_pass   = 0;
    exp_t   sbq [$];
    int     mb [64];
    longint mx [64];
    longint res [64];
    longint ref_x [64];
    int     m_cnt;
    bit     m_conv;
    int     last_cnt;
    bit     last_conv;
    int     ref_b [16] = '{100, -250, 375, -500, 625, -750, 875, -1000,
                           1125, -1250, 1375, -1500, 1625, -1750, 1875, -2000};

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Straight sequential Gauss-Seidel in 64-bit integers.
    task automatic model_run(input int n, input int imax, input longint tolv);
        longint s, q, d, df;
        int     c [4] = '{20, -13, 6, -1};
        int     im;
        im = (imax == 0) ? 1 : imax;
        for (int i = 0; i < n; i++) mx[i] = 0;
        m_cnt  = 0;
        m_conv = 0;
        for (int sw = 0; sw < 70000; sw++) begin
            d = 0;
            for (int i = 0; i < n; i++) begin
                s = longint'(mb[i]) * 65536;
                for (int k = 1; k <= 3; k++) begin
                    if (i - k >= 0) s -= longint'(c[k]) * mx[i-k];
                    if (i + k < n)  s -= longint'(c[k]) * mx[i+k];
                end
                q = (s * 52429 + 524288) >>> 20;
                if (q > 64'sd2147483647) q = 64'sd2147483647;
                if (q < -64'sd2147483648) q = -64'sd2147483648;
                df = q - mx[i];
                if (df < 0) df = -df;
                if (df > d) d = df;
                mx[i] = q;
            end
            m_cnt++;
            if (d <= tolv) begin
                m_conv = 1;
                break;
            end
            if (m_cnt == im) break;
        end
    endtask

    task automatic load(input int inst, input int n, input int imax, input longint tolv,
                        input int gap_max);
        for (int k = 0; k < n; k++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    @(negedge clk);
                    in_en[inst] = 1'b0;
                end
            end
            @(negedge clk);
            in_en[inst]    = 1'b1;
            b_in[inst]     = 16'(mb[k]);
            // Later values must be ignored: only the first accepted b samples them.
            iter_max[inst] = (k == 0) ? 16'(imax) : 16'd2;
            tol[inst]      = (k == 0) ? 32'(tolv) : 32'hffff_ffff;
        end
        @(negedge clk);
        in_en[inst] = 1'b0;
    endtask

    task automatic run(input int inst, input int n, input int imax, input longint tolv,
                       input int gap_max, input bit bp, input bit poke);
        int          lat, exp_lat, got, cyc;
        bit          rdy, stall;
        logic [31:0] hx;
        logic [5:0]  hi;
        exp_t        e;
        model_run(n, imax, tolv);
        for (int i = 0; i < n; i++) begin
            e.idx  = i;
            e.x    = mx[i];
            e.cnt  = m_cnt;
            e.conv = m_conv;
            sbq.push_back(e);
        end
        exp_lat = m_cnt * n + 1;
        load(inst, n, imax, tolv, gap_max);
        check($sformatf("in_ready_low%0d", inst), longint'(in_ready[inst]), 0);
        check($sformatf("busy_high%0d", inst), longint'(busy[inst]), 1);
        lat = 0;
        while (!out_valid[inst] && lat < exp_lat + 20) begin
            if (poke && lat == 3) begin
                in_en[inst] = 1'b1;
                b_in[inst]  = 16'h7fff;
            end else begin
                in_en[inst] = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        in_en[inst] = 1'b0;
        check($sformatf("latency%0d", inst), lat, exp_lat);
        got   = 0;
        cyc   = 0;
        stall = 0;
        while (got < n && cyc < 40 * n) begin
            if (stall) begin
                check("stall_x", longint'(x_out[inst]), longint'(hx));
                check("stall_idx", longint'(out_idx[inst]), longint'(hi));
            end
            rdy = bp ? 1'($urandom_range(1, 0)) : 1'b1;
            out_ready[inst] = rdy;
            stall = 0;
            if (out_valid[inst]) begin
                if (rdy) begin
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        check("out_idx", longint'(out_idx[inst]), e.idx);
                        check($sformatf("x[%0d]", e.idx), longint'($signed(x_out[inst])), e.x);
                        check("iter_cnt", longint'(iter_cnt[inst]), e.cnt);
                        check("converged", longint'(converged[inst]), longint'(e.conv));
                    end
                    res[int'(out_idx[inst])] = longint'($signed(x_out[inst]));
                    last_cnt  = int'(iter_cnt[inst]);
                    last_conv = converged[inst];
                    got++;
                end else begin
                    stall = 1;
                    hx    = x_out[inst];
                    hi    = out_idx[inst];
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready[inst] = 1'b0;
        check("out_count", got, n);
        check("in_ready_back", longint'(in_ready[inst]), 1);
        check("out_valid_low", longint'(out_valid[inst]), 0);
        sbq.delete();
    endtask

    task automatic resid(input int n, input string tag);
        real ssr, r;
        int  c [4] = '{20, -13, 6, -1};
        int  dd;
        ssr = 0.0;
        for (int i = 0; i < n; i++) begin
            r = -real'(mb[i]);
            for (int j = 0; j < n; j++) begin
                dd = (i > j) ? i - j : j - i;
                if (dd <= 3) r += real'(c[dd]) * real'(res[j]) / 65536.0;
            end
            ssr += r * r;
        end
        check(tag, longint'(ssr < 1.0e-3), 1);
    endtask

    task automatic chk_reset(input string p);
        check({p, "_in_ready"}, longint'(in_ready[0]), 1);
        check({p, "_busy"}, longint'(busy[0]), 0);
        check({p, "_out_valid"}, longint'(out_valid[0]), 0);
        check({p, "_x_out"}, longint'(x_out[0]), 0);
        check({p, "_out_idx"}, longint'(out_idx[0]), 0);
        check({p, "_converged"}, longint'(converged[0]), 0);
        check({p, "_iter_cnt"}, longint'(iter_cnt[0]), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int mism;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_en[i]     = 1'b0;
            b_in[i]      = '0;
            iter_max[i]  = '0;
            tol[i]       = '0;
            out_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset = 1'b1;
        @(negedge clk);

        // Reference vector
        for (int i = 0; i < 16; i++) mb[i] = ref_b[i];
        run(0, 16, 200, 0, 0, 0, 0);
        resid(16, "ref_resid");
        for (int i = 0; i < 16; i++) ref_x[i] = res[i];

        // Zero vector
        for (int i = 0; i < 16; i++) mb[i] = 0;
        run(0, 16, 50, 0, 0, 0, 0);
        check("zero_cnt", last_cnt, 1);
        check("zero_conv", longint'(last_conv), 1);

        // Iteration cap
        for (int i = 0; i < 16; i++) mb[i] = ref_b[i];
        run(0, 16, 3, 0, 0, 0, 0);
        check("cap_cnt", last_cnt, 3);
        check("cap_conv", longint'(last_conv), 0);

        // Input gaps and output backpressure
        run(0, 16, 200, 0, 3, 1, 0);
        mism = 0;
        for (int i = 0; i < 16; i++) if (res[i] != ref_x[i]) mism++;
        check("gap_bp_identical", mism, 0);

        // Ignored in_en during ITER
        run(0, 16, 200, 0, 0, 0, 1);
        mism = 0;
        for (int i = 0; i < 16; i++) if (res[i] != ref_x[i]) mism++;
        check("poke_identical", mism, 0);

        // Reset during sweep 2, then a zero-vector run
        load(0, 16, 200, 0, 0);
        repeat (22) @(negedge clk);
        check("busy_pre_reset", longint'(busy[0]), 1);
        reset = 1'b0;
        #1;
        chk_reset("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) mb[i] = 0;
        run(0, 16, 50, 0, 0, 0, 0);
        check("post_rst_cnt", last_cnt, 1);

        // N=8, b = 1..8
        for (int i = 0; i < 8; i++) mb[i] = i + 1;
        run(1, 8, 200, 0, 0, 0, 0);
        resid(8, "n8_resid");

        // N=4, b = -1
        for (int i = 0; i < 4; i++) mb[i] = -1;
        run(2, 4, 200, 0, 0, 0, 0);
        resid(4, "n4_resid");
        check("n4_sym03", longint'((res[0] - res[3] <= 16) && (res[3] - res[0] <= 16)), 1);
        check("n4_sym12", longint'((res[1] - res[2] <= 16) && (res[2] - res[1] <= 16)), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
